// File: rtl/rx_pkg.sv
// rx_pkg: shared state type, character codes and default depth for the RX line buffer
package rx_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam int DEPTH_DEF = 16;
endpackage

// File: rtl/rx_char_ram.sv
// rx_char_ram: DEPTH x 8 character store, one write port and one registered read port
module rx_char_ram #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // write when enabled; read data registered, old data on same-address collision
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/rx_line_buffer.sv
// rx_line_buffer: UART line editor with backspace, CR/clear sweep and optional echo (RX_ECHO_EN)
module rx_line_buffer
  import rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_we,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_char,
  output logic [$clog2(DEPTH):0]   line_len,
  output logic [7:0]               last_char,
  output logic                     line_done,
  output logic                     busy,
  output logic                     overflow,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  state_t state;
  logic [AW-1:0] idx;
  logic rd_ok;
  logic [7:0] ram_q;
  logic [6:0] c;
  logic is_pr, is_bs, is_cr, full, wr_char, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_d;
  assign c = rx_data[6:0];
  assign is_pr = c >= CH_SP[6:0] && c <= CH_TILDE[6:0];
  assign is_bs = c == CH_BS[6:0];
  assign is_cr = c == CH_CR[6:0];
  assign full = line_len == LW'(DEPTH);
  assign busy = state == CLEAR;
  // storage write port: accepted character in IDLE, zero sweep in CLEAR
  always_comb begin
    wr_char = state == IDLE && !clr && rx_we && is_pr && !full;
    ram_we = wr_char || state == CLEAR;
    ram_addr = state == CLEAR ? idx : line_len[AW-1:0];
    ram_d = state == CLEAR ? 8'h00 : rx_data;
  end
  rx_char_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(ram_we), .waddr(ram_addr), .wdata(ram_d),
    .raddr(rd_addr), .rdata(ram_q)
  );
  assign rd_char = rd_ok ? ram_q : 8'h00;
  // line editing FSM: IDLE accepts bytes, CLEAR zeroes one entry per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      line_len <= '0;
      last_char <= 8'h00;
      line_done <= 1'b0;
      overflow <= 1'b0;
      rd_ok <= 1'b0;
    end else begin
      line_done <= 1'b0;
      rd_ok <= {1'b0, rd_addr} < line_len;
      if (state == IDLE) begin
        if (clr) begin
          state <= CLEAR;
          idx <= '0;
          line_len <= '0;
          overflow <= rx_we;
        end else if (rx_we) begin
          if (is_pr) begin
            if (full) overflow <= 1'b1;
            else begin
              line_len <= line_len + 1'b1;
              last_char <= rx_data;
            end
          end else if (is_bs) begin
            if (line_len != '0) line_len <= line_len - 1'b1;
          end else if (is_cr) begin
            line_done <= 1'b1;
            state <= CLEAR;
            idx <= '0;
            line_len <= '0;
          end
        end
      end else begin
        if (rx_we) overflow <= 1'b1;
        idx <= idx + 1'b1;
        if (idx == AW'(DEPTH - 1)) state <= IDLE;
      end
    end
  end
`ifdef RX_ECHO_EN
  logic acc, pend_v;
  logic [7:0] pend_d;
  assign acc = state == IDLE && !clr && rx_we && ((is_pr && !full) || is_bs || is_cr);
  // echo accepted bytes, holding one byte while the transmitter is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      pend_v <= 1'b0;
      pend_d <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      if (pend_v) begin
        if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data <= pend_d;
          pend_v <= 1'b0;
        end
      end else if (acc) begin
        if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data <= rx_data;
        end else begin
          pend_v <= 1'b1;
          pend_d <= rx_data;
        end
      end
    end
  end
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_start = 1'b0;
  assign tx_data = 8'h00;
`endif
endmodule

// File: tb/tb_rx_line_buffer.sv
// tb_rx_line_buffer: directed table and sequence checks for rx_line_buffer
module tb_rx_line_buffer;
  logic clk = 0, rst = 1, rx_we = 0, clr = 0, tx_busy = 0;
  logic [7:0] rx_data = 0;
  logic [3:0] rd_addr = 0;
  logic [7:0] rd_char, last_char, tx_data;
  logic [4:0] line_len;
  logic line_done, busy, overflow, tx_start;
  int total = 0, fails = 0;

  rx_line_buffer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_we(rx_we), .clr(clr),
    .rd_addr(rd_addr), .rd_char(rd_char), .line_len(line_len), .last_char(last_char),
    .line_done(line_done), .busy(busy), .overflow(overflow),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [4:0] len;
    logic [7:0] last;
    logic ovf;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; rx_we = 0; clr = 0; tx_busy = 0; rd_addr = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_we = 1;
    @(negedge clk);
    rx_we = 0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    rd_addr = a;
    @(negedge clk);
    chk(name, rd_char, exp);
  endtask

  initial begin
    int cnt, starts;
    logic [7:0] seen;
    v[0]  = '{8'h41, 5'd1, 8'h41, 1'b0};
    v[1]  = '{8'h42, 5'd2, 8'h42, 1'b0};
    v[2]  = '{8'hC3, 5'd3, 8'hC3, 1'b0};
    v[3]  = '{8'h07, 5'd3, 8'hC3, 1'b0};
    v[4]  = '{8'hFF, 5'd3, 8'hC3, 1'b0};
    v[5]  = '{8'h08, 5'd2, 8'hC3, 1'b0};
    v[6]  = '{8'h88, 5'd1, 8'hC3, 1'b0};
    v[7]  = '{8'h08, 5'd0, 8'hC3, 1'b0};
    v[8]  = '{8'h08, 5'd0, 8'hC3, 1'b0};
    v[9]  = '{8'h20, 5'd1, 8'h20, 1'b0};
    v[10] = '{8'h7E, 5'd2, 8'h7E, 1'b0};

    do_reset();
    chk("rst_len", line_len, 0);
    chk("rst_last", last_char, 0);
    chk("rst_done", line_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_txs", tx_start, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_rd", rd_char, 0);

    for (int i = 0; i < 11; i++) begin
      send(v[i].d);
      chk($sformatf("vec%0d_len", i), line_len, v[i].len);
      chk($sformatf("vec%0d_last", i), last_char, v[i].last);
      chk($sformatf("vec%0d_ovf", i), overflow, v[i].ovf);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    do_reset();
    send(8'h41); send(8'h42); send(8'hC3);
    chk("abc_len", line_len, 3);
    chk("abc_last", last_char, 8'hC3);
    rd(2, 8'hC3, "abc_rd2");
    rd(0, 8'h41, "abc_rd0");
    rd(3, 8'h00, "abc_rd3_empty");

    do_reset();
    send(8'h41); send(8'h42); send(8'h08); send(8'h08); send(8'h08);
    chk("bs_len", line_len, 0);
    chk("bs_ovf", overflow, 0);

    do_reset();
    for (int i = 0; i < 17; i++) send(8'h41 + 8'(i));
    chk("full_len", line_len, 16);
    chk("full_ovf", overflow, 1);
    chk("full_last", last_char, 8'h50);
    rd(15, 8'h50, "full_rd15");
    rd(0, 8'h41, "full_rd0");

    do_reset();
    send(8'h41); send(8'h42); send(8'h43);
    send(8'h0D);
    chk("cr_done", line_done, 1);
    chk("cr_busy", busy, 1);
    chk("cr_len", line_len, 0);
    cnt = 1;
    send(8'h41);
    chk("cr_done_pulse", line_done, 0);
    if (busy) cnt++;
    for (int k = 0; k < 40 && busy; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("cr_busy_cycles", cnt, 16);
    chk("cr_len_after", line_len, 0);
    chk("cr_ovf", overflow, 1);
    rd(0, 8'h00, "cr_rd0_empty");
    send(8'h44);
    chk("cr_idle_len", line_len, 1);
    rd(0, 8'h44, "cr_rd0_new");

    do_reset();
    send(8'h41); send(8'h42);
    clr = 1; rx_data = 8'h41; rx_we = 1;
    @(negedge clk);
    clr = 0; rx_we = 0;
    chk("clrwe_busy", busy, 1);
    chk("clrwe_len", line_len, 0);
    chk("clrwe_ovf", overflow, 1);
    chk("clrwe_done", line_done, 0);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk("clrwe_idle", busy, 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clr_ovf_cleared", overflow, 0);
    cnt = busy ? 1 : 0;
    for (int k = 0; k < 40 && busy; k++) begin
      if (k == 2) clr = 1;
      @(negedge clk);
      clr = 0;
      if (busy) cnt++;
    end
    chk("clr_ignored_cycles", cnt, 16);
    chk("clr_ovf_stays", overflow, 0);

    send(8'h0D);
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_len", line_len, 0);
    rd(0, 8'h00, "abort_rd0");

`ifdef RX_ECHO_EN
    do_reset();
    tx_busy = 1;
    send(8'h41);
    chk("echo_hold1", tx_start, 0);
    send(8'h42);
    chk("echo_hold2", tx_start, 0);
    chk("echo_len", line_len, 2);
    tx_busy = 0;
    starts = 0; seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tx_start) begin starts++; seen = tx_data; end
    end
    chk("echo_starts", starts, 1);
    chk("echo_data", seen, 8'h41);
`else
    do_reset();
    tx_busy = 0;
    starts = 0;
    send(8'h41);
    for (int k = 0; k < 3; k++) begin
      if (tx_start) starts++;
      @(negedge clk);
    end
    chk("noecho_starts", starts, 0);
    chk("noecho_data", tx_data, 0);
    seen = 0;
    chk("noecho_seen", seen | tx_data, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
